// File: rtl/port_stream_bridge_pkg.sv
// Shared constants and helpers for the CPU-port to valid/ready stream bridge.
// Holds the status/control bit map, the data width and the status word packer.
package port_pkg;

    localparam int DATA_W = 16;

    localparam int ST_RX_AVAIL   = 0;
    localparam int ST_TX_FULL    = 1;
    localparam int ST_TX_EMPTY   = 2;
    localparam int ST_RX_UNDER   = 3;
    localparam int ST_TX_OVER    = 4;
    localparam int ST_RX_CNT_LSB = 8;
    localparam int ST_TX_CNT_LSB = 12;

    localparam int CTL_IS_CTRL  = 15;
    localparam int CTL_CLR      = 0;
    localparam int CTL_FLUSH_TX = 1;
    localparam int CTL_FLUSH_RX = 2;

    function automatic logic depth_ok(input int depth);
        return (depth == 2) || (depth == 4) || (depth == 8);
    endfunction

    // Bits [7:5] are reserved and always read as zero.
    function automatic logic [DATA_W-1:0] pack_status(
        input logic       rx_avail,
        input logic       tx_full,
        input logic       tx_empty,
        input logic       rx_under,
        input logic       tx_over,
        input logic [3:0] rx_count,
        input logic [3:0] tx_count
    );
        logic [DATA_W-1:0] s;
        s                       = 16'h0000;
        s[ST_RX_AVAIL]          = rx_avail;
        s[ST_TX_FULL]           = tx_full;
        s[ST_TX_EMPTY]          = tx_empty;
        s[ST_RX_UNDER]          = rx_under;
        s[ST_TX_OVER]           = tx_over;
        s[ST_RX_CNT_LSB +: 4]   = rx_count;
        s[ST_TX_CNT_LSB +: 4]   = tx_count;
        return s;
    endfunction

endpackage

// File: rtl/port_stream_bridge_if.sv
// Bus bundle between the CPU port / stream environment and the bridge.
// The master side is the CPU plus stream peers; the slave side is the bridge.
interface port_stream_bridge_if;
    import port_pkg::*;

    logic [DATA_W-1:0] cpu_data;
    logic [DATA_W-1:0] cpu_ctrl;
    logic              inform_write;
    logic              inform_read;
    logic [DATA_W-1:0] dev_data;
    logic [DATA_W-1:0] dev_status;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;

    modport master (
        output cpu_data, cpu_ctrl, inform_write, inform_read,
        output tx_ready, rx_data, rx_valid,
        input  dev_data, dev_status, tx_data, tx_valid, rx_ready
    );

    modport slave (
        input  cpu_data, cpu_ctrl, inform_write, inform_read,
        input  tx_ready, rx_data, rx_valid,
        output dev_data, dev_status, tx_data, tx_valid, rx_ready
    );

endinterface

// File: rtl/port_stream_bridge_fifo.sv
// Synchronous first-word-fall-through FIFO used for both bridge directions.
// Pointers wrap modulo DEPTH (a power of two); occupancy is a separate counter.
module port_fifo
    import port_pkg::*;
#(
    parameter int  DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              flush,
    output logic [DATA_W-1:0] head,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [CW-1:0]     count_r;
    logic              push_ok_s;
    logic              pop_ok_s;

    // Flags, qualified push/pop and the zero-when-empty head word.
    always_comb begin
        empty     = (count_r == CW'(0));
        full      = (count_r == CW'(DEPTH));
        count     = count_r;
        // A push into a full FIFO is only legal alongside a pop; flush beats both.
        push_ok_s = push & (~full | pop) & ~flush;
        pop_ok_s  = pop & ~empty & ~flush;
        if (empty) begin
            head = {DATA_W{1'b0}};
        end else begin
            head = mem_r[rd_ptr_r];
        end
    end

    // Pointer and occupancy state.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents are don't-care whenever count says so.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/port_stream_bridge.sv
// Device-side responder for one CPU I/O port: CPU writes feed a TX stream,
// an RX stream feeds CPU reads, with a status word mirrored back to the CPU.
module port_stream_bridge
    import port_pkg::*;
#(
    parameter int TX_DEPTH = 8,
    parameter int RX_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    port_stream_bridge_if.slave  bus
);

    localparam int TX_CW = $clog2(TX_DEPTH) + 1;
    localparam int RX_CW = $clog2(RX_DEPTH) + 1;

    generate
        if (!depth_ok(TX_DEPTH) || !depth_ok(RX_DEPTH)) begin : g_bad_depth
            $error("port_stream_bridge: TX_DEPTH and RX_DEPTH must be 2, 4 or 8");
        end
    endgenerate

    logic              data_wr_s;
    logic              ctrl_wr_s;
    logic              clr_s;
    logic              flush_tx_s;
    logic              flush_rx_s;
    logic              tx_beat_s;
    logic              tx_push_s;
    logic              rx_beat_s;
    logic              rx_pop_s;
    logic              tx_over_set_s;
    logic              rx_under_set_s;
    logic [DATA_W-1:0] tx_head_s;
    logic [DATA_W-1:0] rx_head_s;
    logic [TX_CW-1:0]  tx_count_s;
    logic [RX_CW-1:0]  rx_count_s;
    logic              tx_full_s;
    logic              tx_empty_s;
    logic              rx_full_s;
    logic              rx_empty_s;
    logic              tx_over_r;
    logic              rx_under_r;
    logic              unused_ctrl_s;

    assign unused_ctrl_s = ^bus.cpu_ctrl[14:3];

    // Write decode and the per-cycle transfer/flag events.
    always_comb begin
        data_wr_s      = bus.inform_write & ~bus.cpu_ctrl[CTL_IS_CTRL];
        ctrl_wr_s      = bus.inform_write &  bus.cpu_ctrl[CTL_IS_CTRL];
        clr_s          = ctrl_wr_s & bus.cpu_ctrl[CTL_CLR];
        flush_tx_s     = ctrl_wr_s & bus.cpu_ctrl[CTL_FLUSH_TX];
        flush_rx_s     = ctrl_wr_s & bus.cpu_ctrl[CTL_FLUSH_RX];
        tx_beat_s      = ~tx_empty_s & bus.tx_ready;
        // A full TX still accepts a word when the head leaves in the same cycle.
        tx_push_s      = data_wr_s & (~tx_full_s | tx_beat_s);
        tx_over_set_s  = data_wr_s & tx_full_s & ~tx_beat_s;
        rx_beat_s      = bus.rx_valid & ~rx_full_s;
        // Emptiness is judged on registered state, so a same-cycle RX beat cannot serve this read.
        rx_pop_s       = bus.inform_read & ~rx_empty_s;
        rx_under_set_s = bus.inform_read & rx_empty_s;
    end

    port_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (tx_push_s),
        .push_data (bus.cpu_data),
        .pop       (tx_beat_s),
        .flush     (flush_tx_s),
        .head      (tx_head_s),
        .count     (tx_count_s),
        .full      (tx_full_s),
        .empty     (tx_empty_s)
    );

    port_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rx_beat_s),
        .push_data (bus.rx_data),
        .pop       (rx_pop_s),
        .flush     (flush_rx_s),
        .head      (rx_head_s),
        .count     (rx_count_s),
        .full      (rx_full_s),
        .empty     (rx_empty_s)
    );

    // Sticky error flags; a same-cycle setting event wins over the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_over_r  <= 1'b0;
            rx_under_r <= 1'b0;
        end else begin
            tx_over_r  <= (tx_over_r  & ~clr_s) | tx_over_set_s;
            rx_under_r <= (rx_under_r & ~clr_s) | rx_under_set_s;
        end
    end

    // Every output is a pure function of flops, so none has an input-to-output path.
    always_comb begin
        bus.tx_valid   = ~tx_empty_s;
        bus.tx_data    = tx_head_s;
        bus.rx_ready   = ~rx_full_s;
        bus.dev_data   = rx_head_s;
        bus.dev_status = pack_status(~rx_empty_s, tx_full_s, tx_empty_s,
                                     rx_under_r, tx_over_r,
                                     4'(rx_count_s), 4'(tx_count_s));
    end

endmodule
